// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: funct3 size codes, FSM states
// and the size/width helper functions.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  function automatic bit lsu_width_ok(input int dw);
    return (dw == 32) || (dw == 64);
  endfunction

  // log2 of the access size in bytes; codes not legal for this width fall back to full width
  function automatic logic [1:0] lsu_size(input logic [2:0] f3, input int dw);
    logic [1:0] full;
    full = (dw == 64) ? 2'd3 : 2'd2;
    case (f3)
      LSU_B, LSU_BU: return 2'd0;
      LSU_H, LSU_HU: return 2'd1;
      LSU_W, LSU_WU: return 2'd2;
      default:       return full;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-path lane selector: picks the addressed lane out of the memory word and
// sign- or zero-extends it to the full register width.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic [2:0]                    funct3,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  output logic [DATA_WIDTH-1:0]         data
);

  logic [DATA_WIDTH-1:0] lane_s;
  logic [1:0]            size_s;
  logic                  fill_s;
  int                    nbits_s;

  // Shift the addressed lane down to bit 0 and extend above the access size
  always_comb begin
    lane_s  = rdata >> {offset, 3'b000};
    size_s  = lsu_size(funct3, DATA_WIDTH);
    nbits_s = 8 << size_s;
    case (size_s)
      2'd0:    fill_s = lane_s[7];
      2'd1:    fill_s = lane_s[15];
      2'd2:    fill_s = lane_s[31];
      default: fill_s = lane_s[DATA_WIDTH-1];
    endcase
    fill_s = fill_s & ~funct3[2];
    data   = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < nbits_s) begin
        data[i] = lane_s[i];
      end else begin
        data[i] = fill_s;
      end
    end
  end

endmodule

// File: rtl/lsu_bridge.sv
// Load/store bridge between the control matrix and a handshaked data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating them.
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    wr_i,
  input  logic [2:0]              funct3_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wd_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   rd_o,
  output logic                    misalign_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);

  if (!lsu_width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("lsu_bridge: DATA_WIDTH must be 32 or 64");
  end

  lsu_state_t            state_r;
  logic                  busy_r, done_r, misalign_r, req_r, we_r;
  logic [2:0]            f3_r;
  logic [OFF_W-1:0]      off_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [NB-1:0]         be_r;
  logic [DATA_WIDTH-1:0] wdata_r, rd_r, ext_s, wdata_s;
  logic [1:0]            size_s;
  logic [OFF_W-1:0]      off_s, off_al_s, size_mask_s;
  logic [NB-1:0]         be_s;
  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic                  misal_s;

  // Decode the incoming request into lanes, aligned offset and word address
  always_comb begin
    size_s      = lsu_size(funct3_i, DATA_WIDTH);
    off_s       = addr_i[OFF_W-1:0];
    size_mask_s = OFF_W'((32'd1 << size_s) - 32'd1);
    off_al_s    = off_s & ~size_mask_s;
    be_s        = NB'((32'd1 << (32'd1 << size_s)) - 32'd1) << off_al_s;
    wdata_s     = wd_i << {off_al_s, 3'b000};
    word_addr_s = {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LSU_MISALIGN_TRAP_EN
    misal_s     = (off_s & size_mask_s) != {OFF_W{1'b0}};
`else
    misal_s     = 1'b0;
`endif
  end

  lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .rdata  (mem_rdata_i),
    .funct3 (f3_r),
    .offset (off_r),
    .data   (ext_s)
  );

  // Access FSM; every output is a register updated on the state transition
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      f3_r       <= 3'b000;
      off_r      <= {OFF_W{1'b0}};
      addr_r     <= {ADDR_WIDTH{1'b0}};
      be_r       <= {NB{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      rd_r       <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
          if (start_i) begin
            we_r    <= wr_i;
            f3_r    <= funct3_i;
            off_r   <= off_al_s;
            addr_r  <= word_addr_s;
            be_r    <= be_s;
            wdata_r <= wdata_s;
            busy_r  <= 1'b1;
            if (misal_s) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              misalign_r <= 1'b1;
            end else begin
              state_r <= ST_REQ;
              req_r   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            state_r <= ST_DONE;
            req_r   <= 1'b0;
            done_r  <= 1'b1;
            if (!we_r) begin
              rd_r <= ext_s;
            end
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
          req_r      <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign misalign_o  = misalign_r;
  assign rd_o        = rd_r;
  assign mem_req_o   = req_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_be_o    = be_r;
  assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_lsu_bridge.sv
// Directed self-checking bench for lsu_bridge (DATA_WIDTH=32) with a handshaked memory model.
module tb_lsu_bridge;

  logic        clk = 1'b0;
  logic        reset_i, start_i, wr_i, mem_ack_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wd_i, mem_rdata_i;
  logic        busy_o, done_o, misalign_o, mem_req_o, mem_we_o;
  logic [31:0] rd_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .wr_i        (wr_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wd_i        (wd_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_o        (rd_o),
    .misalign_o  (misalign_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE; returns what the memory side saw and when done_o appeared
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_cyc, input logic [31:0] rdata,
                        input bit poke,
                        output int req_cyc, output int done_cyc, output logic [3:0] be,
                        output logic [31:0] maddr, output logic [31:0] wdata,
                        output logic we, output logic mis, output logic busy_d);
    req_cyc = 0; done_cyc = -1; be = 4'h0; maddr = 32'h0; wdata = 32'h0;
    we = 1'b0; mis = 1'b0; busy_d = 1'b0;
    wr_i = wr; funct3_i = f3; addr_i = addr; wd_i = wd; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (done_o) begin
        done_cyc = cyc; mis = misalign_o; busy_d = busy_o; start_i = 1'b0;
        break;
      end
      if (mem_req_o) begin
        if (req_cyc == 0) begin
          be = mem_be_o; maddr = mem_addr_o; wdata = mem_wdata_o; we = mem_we_o;
        end
        req_cyc++;
        mem_ack_i   = (cyc >= 1 + wait_cyc);
        mem_rdata_i = rdata;
        if (poke) begin
          start_i = 1'b1;
          addr_i  = 32'h60;
        end
      end
      tick;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    end
    start_i = 1'b0;
    tick;
  endtask

  int rq, dn, cnt_done, cnt_req;
  logic [3:0]  be;
  logic [31:0] ma, wdat;
  logic        we, mis, bz;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; wr_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wd_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tick; tick; tick;
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_rd", 64'(rd_o), 64'h0);
    chk("rst_mem", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, misalign_o}), 64'h0);
    chk("rst_wdata", 64'(mem_wdata_o), 64'h0);
    reset_i = 1'b0;
    tick;

    // LW zero-wait
    access(1'b0, 3'b010, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("lw_addr", 64'(ma), 64'h40);
    chk("lw_be", 64'(be), 64'hF);
    chk("lw_we", 64'(we), 64'h0);
    chk("lw_done_cyc", 64'(dn), 64'd2);
    chk("lw_req_cyc", 64'(rq), 64'd1);
    chk("lw_busy_done", 64'(bz), 64'h1);
    chk("lw_rd", 64'(rd_o), 64'hDEADBEEF);
    chk("idle_busy", 64'(busy_o), 64'h0);

    // LB / LBU at byte 3
    access(1'b0, 3'b000, 32'h43, 32'h0, 0, 32'h80112233, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("lb_be", 64'(be), 64'h8);
    chk("lb_rd", 64'(rd_o), 64'hFFFFFF80);
    access(1'b0, 3'b100, 32'h43, 32'h0, 0, 32'h80112233, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("lbu_be", 64'(be), 64'h8);
    chk("lbu_rd", 64'(rd_o), 64'h00000080);

    // SH with ack delayed: req held 3 cycles
    access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 2, 32'hFFFFFFFF, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("sh_be", 64'(be), 64'hC);
    chk("sh_wdata", 64'(wdat), 64'hABCD0000);
    chk("sh_addr", 64'(ma), 64'h100);
    chk("sh_we", 64'(we), 64'h1);
    chk("sh_req_cyc", 64'(rq), 64'd3);
    chk("sh_done_cyc", 64'(dn), 64'd4);
    chk("sh_rd_kept", 64'(rd_o), 64'h00000080);

    // Half loads, byte and word stores
    access(1'b0, 3'b001, 32'h42, 32'h0, 0, 32'h80017FFF, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("lh_rd", 64'(rd_o), 64'hFFFF8001);
    access(1'b0, 3'b101, 32'h40, 32'h0, 1, 32'h80017FFF, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("lhu_be", 64'(be), 64'h3);
    chk("lhu_rd", 64'(rd_o), 64'h00007FFF);
    access(1'b1, 3'b000, 32'h41, 32'h000000A5, 0, 32'h0, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("sb_be", 64'(be), 64'h2);
    chk("sb_wdata", 64'(wdat), 64'h0000A500);
    access(1'b1, 3'b010, 32'h44, 32'h11223344, 0, 32'h0, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("sw_be", 64'(be), 64'hF);
    chk("sw_addr", 64'(ma), 64'h44);
    chk("sw_wdata", 64'(wdat), 64'h11223344);

    // Unassigned code 111 is a full-width access
    access(1'b0, 3'b111, 32'h48, 32'h0, 0, 32'h87654321, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("f7_be", 64'(be), 64'hF);
    chk("f7_rd", 64'(rd_o), 64'h87654321);

    // start_i held during REQ is ignored
    access(1'b0, 3'b010, 32'h50, 32'h0, 2, 32'h0BADF00D, 1'b1, rq, dn, be, ma, wdat, we, mis, bz);
    chk("poke_addr", 64'(ma), 64'h50);
    chk("poke_req_cyc", 64'(rq), 64'd3);
    chk("poke_rd", 64'(rd_o), 64'h0BADF00D);
    cnt_done = 0; cnt_req = 0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done_o) cnt_done++;
      if (mem_req_o) cnt_req++;
    end
    mem_ack_i = 1'b0;
    chk("stray_done", 64'(cnt_done), 64'd0);
    chk("stray_req", 64'(cnt_req), 64'd0);
    chk("stray_rd", 64'(rd_o), 64'h0BADF00D);

    // Reset during REQ abandons the access
    wr_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h70; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("rstreq_req_before", 64'(mem_req_o), 64'h1);
    reset_i = 1'b1;
    tick;
    chk("rstreq_req_after", 64'(mem_req_o), 64'h0);
    reset_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    cnt_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done_o) cnt_done++;
    end
    mem_ack_i = 1'b0;
    chk("rstreq_done", 64'(cnt_done), 64'd0);
    chk("rstreq_busy", 64'(busy_o), 64'h0);
    chk("rstreq_rd", 64'(rd_o), 64'h0);

    // Misaligned word load
    access(1'b0, 3'b010, 32'h41, 32'h0, 0, 32'hCAFEF00D, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req_cyc", 64'(rq), 64'd0);
    chk("mis_done_cyc", 64'(dn), 64'd1);
    chk("mis_flag", 64'(mis), 64'h1);
    chk("mis_rd", 64'(rd_o), 64'h0);
`else
    chk("mis_addr", 64'(ma), 64'h40);
    chk("mis_be", 64'(be), 64'hF);
    chk("mis_done_cyc", 64'(dn), 64'd2);
    chk("mis_flag", 64'(mis), 64'h0);
    chk("mis_rd", 64'(rd_o), 64'hCAFEF00D);
    access(1'b1, 3'b001, 32'h103, 32'h00005A5A, 0, 32'h0, 1'b0, rq, dn, be, ma, wdat, we, mis, bz);
    chk("mis_sh_be", 64'(be), 64'hC);
    chk("mis_sh_wdata", 64'(wdat), 64'h5A5A0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
